// File: rtl/circuit_pacc_pkg.sv
// Shared types and defaults for the carry-pipelined accumulator.
// Op modes and the default datapath geometry.
package circuit_pacc_pkg;

    typedef enum logic [1:0] {
        PACC_ACC  = 2'd0,
        PACC_SUB  = 2'd1,
        PACC_LOAD = 2'd2,
        PACC_CLR  = 2'd3
    } pacc_mode_e;

    localparam int PACC_W_DEFAULT   = 96;
    localparam int PACC_SEG_DEFAULT = 32;

endpackage

// File: rtl/circuit_pacc_if.sv
// Op/result bundle between an op source (master) and the accumulator (slave).
// Result fields are all registered inside the accumulator.
interface circuit_pacc_if
    import circuit_pacc_pkg::*;
#(
    parameter int W = PACC_W_DEFAULT
) ();
    logic         en;
    pacc_mode_e   mode;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         y_valid;
    logic         ovf;

    modport master (output en, output mode, output X, input Y, input y_valid, input ovf);
    modport slave  (input en, input mode, input X, output Y, output y_valid, output ovf);
endinterface

// File: rtl/circuit_pacc_seg.sv
// One SEG-bit slice of the accumulator: holds its acc segment and the carry
// it hands to the next slice one cycle later.
module circuit_pacc_seg
    import circuit_pacc_pkg::*;
#(
    parameter int SEG = PACC_SEG_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  pacc_mode_e     mode,
    input  logic [SEG-1:0] x,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    logic [SEG-1:0] acc_r;
    logic           co_r;
    logic [SEG-1:0] acc_nxt_s;
    logic           co_nxt_s;

    // Next segment value and carry-out for the op at this slice
    always_comb begin
        acc_nxt_s = acc_r;
        co_nxt_s  = 1'b0;
        if (en) begin
            case (mode)
                PACC_ACC: {co_nxt_s, acc_nxt_s} = {1'b0, acc_r} + {1'b0, x} + {{SEG{1'b0}}, ci};
                PACC_SUB: {co_nxt_s, acc_nxt_s} = {1'b0, acc_r} + {1'b0, ~x} + {{SEG{1'b0}}, ci};
                PACC_LOAD: begin
                    acc_nxt_s = x;
                    co_nxt_s  = 1'b0;
                end
                PACC_CLR: begin
                    acc_nxt_s = {SEG{1'b0}};
                    co_nxt_s  = 1'b0;
                end
                default: begin
                    acc_nxt_s = acc_r;
                    co_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            acc_nxt_s = acc_r;
            co_nxt_s  = 1'b0;
        end
    end

    // Segment state and registered carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {SEG{1'b0}};
            co_r  <= 1'b0;
        end else begin
            acc_r <= acc_nxt_s;
            co_r  <= co_nxt_s;
        end
    end

    assign s  = acc_r;
    assign co = co_r;
endmodule

// File: rtl/circuit_pacc.sv
// Carry-pipelined W-bit accumulator: NSEG slices, operands skewed in, results
// deskewed out so every Y word belongs to one op; latency NSEG.
module circuit_pacc
    import circuit_pacc_pkg::*;
#(
    parameter int W   = PACC_W_DEFAULT,
    parameter int SEG = PACC_SEG_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    circuit_pacc_if.slave bus
);
    localparam int NSEG = W / SEG;

    logic           en_stage_s   [NSEG];
    pacc_mode_e     mode_stage_s [NSEG];
    logic [SEG-1:0] sum_s        [NSEG];
    logic           carry_s      [NSEG];
    logic [SEG-1:0] aligned_s    [NSEG];
    logic [W-1:0]   y_next_s;
    logic [W-1:0]   y_r;
    logic           en_top_r;
    pacc_mode_e     mode_top_r;
    logic           y_valid_r;
    logic           ovf_r;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int DLY = NSEG - 1 - k;
        logic           en_k_s;
        pacc_mode_e     mode_k_s;
        logic [SEG-1:0] x_k_s;
        logic           ci_k_s;

        if (k == 0) begin : g_head
            assign en_k_s   = bus.en;
            assign mode_k_s = bus.mode;
            assign x_k_s    = bus.X[SEG-1:0];
            assign ci_k_s   = (bus.mode == PACC_SUB);
        end else begin : g_skew
            logic           en_r;
            pacc_mode_e     mode_r;
            logic [SEG-1:0] x_dly_r [k];

            // Control follows the op one slice per cycle; X slice k waits k cycles
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_r   <= 1'b0;
                    mode_r <= PACC_ACC;
                    for (int i = 0; i < k; i++) x_dly_r[i] <= {SEG{1'b0}};
                end else begin
                    en_r       <= en_stage_s[k-1];
                    mode_r     <= mode_stage_s[k-1];
                    x_dly_r[0] <= bus.X[k*SEG +: SEG];
                    for (int i = 1; i < k; i++) x_dly_r[i] <= x_dly_r[i-1];
                end
            end

            assign en_k_s   = en_r;
            assign mode_k_s = mode_r;
            assign x_k_s    = x_dly_r[k-1];
            assign ci_k_s   = carry_s[k-1];
        end

        assign en_stage_s[k]   = en_k_s;
        assign mode_stage_s[k] = mode_k_s;

        circuit_pacc_seg #(.SEG(SEG)) u_seg (
            .clk  (clk),
            .rst  (rst),
            .en   (en_k_s),
            .mode (mode_k_s),
            .x    (x_k_s),
            .ci   (ci_k_s),
            .s    (sum_s[k]),
            .co   (carry_s[k])
        );

        if (DLY == 0) begin : g_nodsk
            assign aligned_s[k] = sum_s[k];
        end else begin : g_dsk
            logic [SEG-1:0] dsk_r [DLY];

            // Lower slices finish early; hold them until the top slice catches up
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DLY; i++) dsk_r[i] <= {SEG{1'b0}};
                end else begin
                    dsk_r[0] <= sum_s[k];
                    for (int i = 1; i < DLY; i++) dsk_r[i] <= dsk_r[i-1];
                end
            end

            assign aligned_s[k] = dsk_r[DLY-1];
        end
    end

    // Pack the aligned slices into one result word
    always_comb begin
        y_next_s = {W{1'b0}};
        for (int k = 0; k < NSEG; k++) y_next_s[k*SEG +: SEG] = aligned_s[k];
    end

    // Output stage: Y/y_valid/ovf for the op that just left the top slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_top_r   <= 1'b0;
            mode_top_r <= PACC_ACC;
            y_r        <= {W{1'b0}};
            y_valid_r  <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            en_top_r   <= en_stage_s[NSEG-1];
            mode_top_r <= mode_stage_s[NSEG-1];
            y_valid_r  <= en_top_r;
            if (en_top_r) begin
                y_r <= y_next_s;
                case (mode_top_r)
                    PACC_ACC:  ovf_r <= ovf_r | carry_s[NSEG-1];
                    PACC_SUB:  ovf_r <= ovf_r | ~carry_s[NSEG-1];
                    PACC_LOAD: ovf_r <= 1'b0;
                    PACC_CLR:  ovf_r <= 1'b0;
                    default:   ovf_r <= ovf_r;
                endcase
            end else begin
                y_r   <= y_r;
                ovf_r <= ovf_r;
            end
        end
    end

    assign bus.Y       = y_r;
    assign bus.y_valid = y_valid_r;
    assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_circuit_pacc.sv
// Self-checking bench for circuit_pacc (W=96, SEG=32): a full-width reference
// model fills a scoreboard that is drained LAT cycles later.
module tb_circuit_pacc;
    import circuit_pacc_pkg::*;

    localparam int W   = 96;
    localparam int SEG = 32;
    localparam int LAT = W / SEG;

    typedef struct packed {
        logic [W-1:0] y;
        logic         valid;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    circuit_pacc_if #(.W(W)) bus ();
    circuit_pacc #(.W(W), .SEG(SEG)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t         sb_q [$];
    logic [W-1:0] acc_m;
    logic [W-1:0] y_m;
    logic         ovf_m;
    int           tests = 0;
    int           fails = 0;
    string        phase = "init";

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
        end
    endtask

    // Pipeline after reset holds only bubbles, so the first LAT outputs are zeros
    task automatic model_reset();
        acc_m = '0;
        y_m   = '0;
        ovf_m = 1'b0;
        sb_q.delete();
        for (int i = 0; i < LAT; i++) sb_q.push_back('{y: '0, valid: 1'b0, ovf: 1'b0});
    endtask

    task automatic step(input logic en, input pacc_mode_e mode, input logic [W-1:0] x);
        exp_t       e;
        logic [W:0] wide;
        @(negedge clk);
        bus.en   = en;
        bus.mode = mode;
        bus.X    = x;
        @(posedge clk);
        if (en) begin
            case (mode)
                PACC_ACC: begin
                    wide  = {1'b0, acc_m} + {1'b0, x};
                    acc_m = wide[W-1:0];
                    if (wide[W]) ovf_m = 1'b1;
                end
                PACC_SUB: begin
                    if (x > acc_m) ovf_m = 1'b1;
                    acc_m = acc_m - x;
                end
                PACC_LOAD: begin
                    acc_m = x;
                    ovf_m = 1'b0;
                end
                default: begin
                    acc_m = '0;
                    ovf_m = 1'b0;
                end
            endcase
            y_m = acc_m;
        end
        sb_q.push_back('{y: y_m, valid: en, ovf: ovf_m});
        #1;
        if (sb_q.size() > LAT) begin
            e = sb_q.pop_front();
            check("Y", bus.Y, e.y);
            check("y_valid", W'(bus.y_valid), W'(e.valid));
            check("ovf", W'(bus.ovf), W'(e.ovf));
        end
    endtask

    task automatic check_zero();
        check("Y", bus.Y, '0);
        check("y_valid", W'(bus.y_valid), '0);
        check("ovf", W'(bus.ovf), '0);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [1:0]   rm;
        logic         re;

        bus.en   = 1'b0;
        bus.mode = PACC_ACC;
        bus.X    = '0;

        phase = "reset";
        #9;
        check_zero();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        phase = "carry";
        step(1'b1, PACC_LOAD, 96'h0000_0000_0000_0000_FFFF_FFFF);
        step(1'b1, PACC_ACC,  96'd1);

        phase = "wrap";
        step(1'b1, PACC_LOAD, {W{1'b1}});
        step(1'b1, PACC_ACC,  96'd1);
        step(1'b1, PACC_ACC,  96'd7);
        step(1'b1, PACC_LOAD, 96'd5);

        phase = "sub";
        step(1'b1, PACC_CLR,  96'd0);
        step(1'b1, PACC_SUB,  96'd1);
        step(1'b1, PACC_LOAD, 96'd10);
        step(1'b1, PACC_SUB,  96'd3);

        phase = "bubble";
        step(1'b1, PACC_CLR,  96'd0);
        step(1'b1, PACC_ACC,  96'd1);
        step(1'b0, PACC_CLR,  96'd9);
        step(1'b0, PACC_LOAD, 96'd9);
        step(1'b1, PACC_ACC,  96'd2);

        phase = "midreset";
        step(1'b1, PACC_ACC,  96'd5);
        step(1'b1, PACC_SUB,  96'd100);
        @(negedge clk);
        bus.en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_zero();
        model_reset();
        #7;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LAT + 1; i++) step(1'b0, PACC_ACC, 96'd0);

        phase = "random";
        void'($urandom(7));
        for (int i = 0; i < 99; i++) begin
            rx = {$urandom, $urandom, $urandom};
            rm = 2'($urandom_range(3, 0));
            re = 1'($urandom_range(1, 0));
            step(re, pacc_mode_e'(rm), rx);
        end

        phase = "flush";
        for (int i = 0; i < LAT; i++) step(1'b0, PACC_ACC, 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
